// File: rtl/key_event_pkg.sv
// Shared key-event definitions, used by the event queue and the menu/game consumer FSM.
package key_event_pkg;

  localparam int unsigned NUM_KEYS = 5;
  localparam int unsigned CODE_W   = 3;
  localparam int unsigned DEPTH    = 8;

  localparam logic [CODE_W-1:0] KEY_UP     = CODE_W'(0);
  localparam logic [CODE_W-1:0] KEY_DOWN   = CODE_W'(1);
  localparam logic [CODE_W-1:0] KEY_LEFT   = CODE_W'(2);
  localparam logic [CODE_W-1:0] KEY_RIGHT  = CODE_W'(3);
  localparam logic [CODE_W-1:0] KEY_CENTER = CODE_W'(4);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered head, valid and occupancy count.
// A push and a pop may both occur on a full FIFO in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && valid_q;
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    // Next head is either already stored or is the word being written this cycle.
    head_d = head_q;
    if (count_d != '0) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Storage array needs no reset: only written entries are ever read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Serialises simultaneous key-press pulses (lowest index first) into a FIFO of key codes,
// holding unqueued presses in a pending register and flagging merged presses as overflow.
module key_event_queue #(
  parameter int unsigned NUM_KEYS = key_event_pkg::NUM_KEYS,
  parameter int unsigned CODE_W   = key_event_pkg::CODE_W,
  parameter int unsigned DEPTH    = key_event_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      key_pulse,
  output logic                     ev_valid,
  output logic [CODE_W-1:0]        ev_code,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] cand, sel;
  logic [CODE_W-1:0]   sel_code;
  logic                overflow_q, overflow_d;
  logic                push, pop, space;
  logic                fifo_valid;
  logic [CNT_W-1:0]    fifo_count;

  always_comb begin
    cand     = pending_q | key_pulse;
    sel      = '0;
    sel_code = '0;
    // Descending scan so the lowest set index wins.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel      = '0;
        sel[i]   = 1'b1;
        sel_code = CODE_W'(i);
      end
    end
    pop        = fifo_valid && ev_ready;
    space      = (fifo_count < FULL_CNT) || pop;
    push       = (|cand) && space;
    pending_d  = push ? (cand & ~sel) : cand;
    overflow_d = overflow_q || (|(key_pulse & pending_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (sel_code),
    .valid_o (fifo_valid),
    .rdata_o (ev_code),
    .count_o (fifo_count)
  );

  assign ev_valid = fifo_valid;
  assign ev_count = fifo_count;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed and scoreboarded checks of key_event_queue: latency, serialisation order,
// saturation and overflow, full-FIFO push/pop, reset discard, random stream.
module tb_key_event_queue;
  import key_event_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] key_pulse;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       ev_ready;
  logic [3:0] ev_count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] m_pend;
  logic       m_ovf;
  logic [2:0] mq[$];

  key_event_queue dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_pulse = 5'b0; ev_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ev_valid); end
    n_vec++; if (ev_count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", ev_count); end
    n_vec++; if (ev_code !== 3'd0) begin n_err++; $display("FAIL reset_code got=%b exp=0", ev_code); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single_key();
    key_pulse = 5'b00100;
    step();
    key_pulse = 5'b0;
    n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", ev_valid); end
    n_vec++; if (ev_code !== KEY_LEFT) begin n_err++; $display("FAIL single_code got=%0d exp=2", ev_code); end
    n_vec++; if (ev_count !== 4'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", ev_count); end
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got=%b exp=0", ev_valid); end
    n_vec++; if (ev_count !== 4'd0) begin n_err++; $display("FAIL single_pop_count got=%0d exp=0", ev_count); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_codes [3];
    exp_codes[0] = KEY_UP; exp_codes[1] = KEY_DOWN; exp_codes[2] = KEY_CENTER;
    ev_ready = 1'b0;
    key_pulse = 5'b10011;
    step();
    key_pulse = 5'b0;
    for (int i = 1; i <= 4; i++) begin
      int exp_cnt;
      exp_cnt = (i > 3) ? 3 : i;
      n_vec++; if (ev_count !== 4'(exp_cnt)) begin n_err++; $display("FAIL simul_count step=%0d got=%0d exp=%0d", i, ev_count, exp_cnt); end
      n_vec++; if (ev_code !== KEY_UP) begin n_err++; $display("FAIL simul_head step=%0d got=%0d exp=0", i, ev_code); end
      if (i < 4) step();
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ev_valid !== 1'b1 || ev_code !== exp_codes[i]) begin n_err++; $display("FAIL simul_pop idx=%0d got valid=%b code=%0d exp code=%0d", i, ev_valid, ev_code, exp_codes[i]); end
      step();
    end
    ev_ready = 1'b0;
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty got=%b exp=0", ev_valid); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_saturate_overflow();
    int got;
    ev_ready = 1'b0;
    for (int p = 1; p <= 10; p++) begin
      key_pulse = 5'b01000;
      step();
      key_pulse = 5'b0;
      step();
      if (p == 8) begin
        n_vec++; if (ev_count !== 4'd8) begin n_err++; $display("FAIL sat_count8 got=%0d exp=8", ev_count); end
      end
      if (p == 9) begin
        n_vec++; if (ev_count !== 4'd8) begin n_err++; $display("FAIL sat_count9 got=%0d exp=8", ev_count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sat_ovf9 got=%b exp=0", overflow); end
      end
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf10 got=%b exp=1", overflow); end
    got = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ev_valid !== 1'b1) break;
      n_vec++; if (ev_code !== KEY_RIGHT) begin n_err++; $display("FAIL sat_drain_code idx=%0d got=%0d exp=3", i, ev_code); end
      got++;
      step();
    end
    ev_ready = 1'b0;
    n_vec++; if (got != 9) begin n_err++; $display("FAIL sat_drain_total got=%0d exp=9", got); end
    n_vec++; if (ev_count !== 4'd0) begin n_err++; $display("FAIL sat_drain_count got=%0d exp=0", ev_count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [2:0] exp_codes [8];
    logic [4:0] fill [8];
    fill[0] = 5'b00010; fill[1] = 5'b00100; fill[2] = 5'b01000; fill[3] = 5'b10000;
    fill[4] = 5'b00010; fill[5] = 5'b00100; fill[6] = 5'b01000; fill[7] = 5'b10000;
    exp_codes[0] = 3'd2; exp_codes[1] = 3'd3; exp_codes[2] = 3'd4; exp_codes[3] = 3'd1;
    exp_codes[4] = 3'd2; exp_codes[5] = 3'd3; exp_codes[6] = 3'd4; exp_codes[7] = 3'd0;
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key_pulse = fill[i];
      step();
    end
    key_pulse = 5'b0;
    n_vec++; if (ev_count !== 4'd8) begin n_err++; $display("FAIL full_fill_count got=%0d exp=8", ev_count); end
    ev_ready = 1'b1; key_pulse = 5'b00001;
    step();
    ev_ready = 1'b0; key_pulse = 5'b0;
    n_vec++; if (ev_count !== 4'd8) begin n_err++; $display("FAIL full_pp_count got=%0d exp=8", ev_count); end
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (ev_valid !== 1'b1 || ev_code !== exp_codes[i]) begin n_err++; $display("FAIL full_drain idx=%0d got valid=%b code=%0d exp code=%0d", i, ev_valid, ev_code, exp_codes[i]); end
      step();
    end
    ev_ready = 1'b0;
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL full_drain_empty got=%b exp=0", ev_valid); end
  endtask

  task automatic test_reset_discard();
    ev_ready = 1'b0;
    key_pulse = 5'b01111;
    step();
    key_pulse = 5'b0;
    step(); step(); step();
    n_vec++; if (ev_count !== 4'd4) begin n_err++; $display("FAIL rstd_pre_count got=%0d exp=4", ev_count); end
    rst = 1'b1; key_pulse = 5'b11111;
    step();
    rst = 1'b0; key_pulse = 5'b0;
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL rstd_valid got=%b exp=0", ev_valid); end
    n_vec++; if (ev_count !== 4'd0) begin n_err++; $display("FAIL rstd_count got=%0d exp=0", ev_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstd_overflow got=%b exp=0", overflow); end
    n_vec++; if (ev_code !== 3'd0) begin n_err++; $display("FAIL rstd_code got=%b exp=0", ev_code); end
    step(); step();
    n_vec++; if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin n_err++; $display("FAIL rstd_no_queue got valid=%b count=%0d exp 0/0", ev_valid, ev_count); end
  endtask

  task automatic test_random_stream(input bit dense, input int cycles);
    logic [4:0] kp, cand;
    logic       m_pop, m_push, found;
    rst = 1'b1; key_pulse = 5'b0; ev_ready = 1'b1;
    step();
    rst = 1'b0;
    m_pend = '0; m_ovf = 1'b0; mq.delete();
    for (int c = 0; c < cycles; c++) begin
      kp = dense ? 5'($urandom & $urandom) : 5'($urandom & $urandom & $urandom & $urandom);
      key_pulse = kp;
      cand = m_pend | kp;
      if ((kp & m_pend) != 5'b0) m_ovf = 1'b1;
      m_pop  = (mq.size() != 0);
      m_push = (cand != 5'b0) && ((mq.size() < 8) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          if (!found && cand[k]) begin
            found = 1'b1;
            mq.push_back(3'(k));
            cand[k] = 1'b0;
          end
        end
      end
      m_pend = cand;
      step();
      n_vec++; if (ev_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, ev_valid, (mq.size() != 0)); end
      n_vec++; if (ev_count !== 4'(mq.size())) begin n_err++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, ev_count, mq.size()); end
      if (mq.size() != 0) begin
        n_vec++; if (ev_code !== mq[0]) begin n_err++; $display("FAIL rand_code cyc=%0d got=%0d exp=%0d", c, ev_code, mq[0]); end
      end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rand_overflow cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
    end
    key_pulse = 5'b0;
  endtask

  initial begin
    rst = 1'b1; key_pulse = 5'b0; ev_ready = 1'b0;
    test_reset();
    test_single_key();
    test_simultaneous();
    test_saturate_overflow();
    test_full_push_pop();
    test_reset_discard();
    test_random_stream(1'b0, 1000);
    test_random_stream(1'b1, 1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
